fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one syncfifo write port among NUM_REQ requesters.
- Each requester sends packets over a valid/ready/last stream. A granted requester keeps the FIFO until its last beat is accepted, so packets never interleave in the FIFO.
- Sits directly in front of syncfifo: drives din/wr_en and consumes full.
- A stall watchdog releases a grant held by a requester that has gone silent.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, beat width; must equal the syncfifo DATA_WIDTH.
- IDLE_TIMEOUT, 16, cycles a granted requester may hold req_valid low before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of a packet.
- req_ready  out  NUM_REQ  per-requester beat accept.
- fifo_din  out  DATA_WIDTH  to syncfifo din.
- fifo_wr_en  out  1  to syncfifo wr_en.
- fifo_full  in  1  from syncfifo full.
- grant_vld  out  1  a requester currently owns the FIFO.
- grant_id  out  $clog2(NUM_REQ)  index of the owner; holds its last value when grant_vld=0.
- timeout_pulse  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, grant_vld=0, grant_id=0, rr_ptr=0, idle_cnt=0, timeout_pulse=0.
  - req_ready=0 and fifo_wr_en=0 for the whole reset cycle, whatever the inputs.
  - Reset mid-packet abandons the packet. Beats already written stay in the FIFO; the arbiter does not mark them.
- FSM states: IDLE, OWN.
- IDLE:
  - req_ready=0, fifo_wr_en=0.
  - If any req_valid bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Register that index into grant_id, set grant_vld=1 and go to OWN.
  - Arbitration latency: 1 cycle. The first beat can transfer at the earliest in the cycle after req_valid is first seen.
- OWN, with g = grant_id:
  - req_ready[g] = ~fifo_full (combinational). All other req_ready bits are 0.
  - Transfer xfer = req_valid[g] & req_ready[g].
  - fifo_wr_en = xfer and fifo_din = req_data[g], both combinational, so there is 0 added latency to the FIFO.
  - fifo_wr_en is never asserted while fifo_full=1, so there is no overflow write.
  - On xfer with req_last[g]=1: go to IDLE, grant_vld=0, rr_ptr = (g+1) mod NUM_REQ.
  - IDLE is held for exactly 1 cycle between packets. Back-to-back packets from different requesters are therefore separated by one dead cycle.
  - A stall caused by fifo_full does not count toward the watchdog.
- Watchdog (IDLE_TIMEOUT>0), in OWN:
  - idle_cnt increments on cycles with req_valid[g]=0 and clears on any cycle with req_valid[g]=1.
  - When idle_cnt reaches IDLE_TIMEOUT-1 and req_valid[g] is still 0: assert timeout_pulse for 1 cycle, go to IDLE, rr_ptr=(g+1) mod NUM_REQ.
  - The rest of the packet from g is then treated as a new packet on its next grant.
  - idle_cnt clears on entry to OWN. Its width is $clog2(IDLE_TIMEOUT+1).
- Fairness: a requester that has just finished is lowest priority at the next arbitration. Worst-case wait is NUM_REQ-1 packets.
- Requester obligations: keep req_valid/req_data/req_last stable while valid=1 and ready=0. The arbiter registers nothing on the data path.
- Withdrawal in IDLE: req_valid dropped before grant is legal. The grant may still be issued; the watchdog eventually reclaims it.
- Simultaneous last beat and new requests: the new requests are arbitrated in the following IDLE cycle with the updated rr_ptr.

Test Plan:
- Single packet:
  - Stimulus: reset 3 cycles; requester 0 sends 4 beats 0x01..0x04 with last on 0x04; FIFO not full.
  - Required: grant_id=0 one cycle after valid; fifo_wr_en high for 4 consecutive cycles with din 0x01..0x04; grant_vld=0 the following cycle.
- Round-robin:
  - Stimulus: all 4 requesters continuously valid with 2-beat packets; requester i data = 0x10*i+beat.
  - Required: grant order 0,1,2,3,0; each pair of FIFO entries is contiguous and from one requester; one dead cycle between packets.
- Backpressure:
  - Stimulus: 16-deep syncfifo, no reads; requester 1 sends a 20-beat packet.
  - Required: exactly 16 writes; fifo_full=1; req_ready[1]=0 with no wr_en while full; after the test reads 4 entries, the remaining 4 beats complete; no timeout_pulse.
- Watchdog:
  - Stimulus: IDLE_TIMEOUT=16; requester 2 sends 2 beats without last, then drops valid; requester 3 is valid.
  - Required: timeout_pulse exactly 16 cycles after the last transfer; grant_id=3 two cycles later.
- Reset mid-packet:
  - Stimulus: assert rst during beat 3 of a 6-beat packet from requester 1.
  - Required: same cycle req_ready=0 and fifo_wr_en=0; after reset rr_ptr=0, so a simultaneous request from 0 and 1 is granted to 0.
- Wrap and fairness:
  - Stimulus: requesters 3 and 0 always valid, 1-beat packets.
  - Required: grants alternate 3,0,3,0 starting from the first grant after rr_ptr wraps past 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet arbiter sharing one syncfifo write port
// A grant is held until the owner's last beat is written; a watchdog reclaims silent grants.
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic                          grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          timeout_pulse
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q;
  logic             grant_vld_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0] idle_cnt_q;

  logic [ID_W-1:0]       pick;
  logic                  found;
  logic                  any_req;
  logic [ID_W-1:0]       rr_ptr_d;
  logic                  owner_valid;
  logic                  owner_last;
  logic                  xfer;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Two passes: indices at or above rr_ptr first, then the wrapped-around ones.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  assign any_req     = |req_valid;
  assign owner_valid = req_valid[grant_id_q];
  assign owner_last  = req_last[grant_id_q];
  assign rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    xfer       = 1'b0;
    timeout    = 1'b0;
    if (!rst && state_q == OWN) begin
      req_ready[grant_id_q] = ~fifo_full;
      xfer                  = owner_valid & ~fifo_full;
      fifo_wr_en            = xfer;
      if (IDLE_TIMEOUT > 0 && !owner_valid && idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
        timeout = 1'b1;
      end
    end
  end

  assign fifo_din      = data_arr[grant_id_q];
  assign grant_vld     = grant_vld_q;
  assign grant_id      = grant_id_q;
  assign timeout_pulse = timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_vld_q <= 1'b0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      idle_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          idle_cnt_q <= '0;
          if (any_req) begin
            state_q     <= OWN;
            grant_vld_q <= 1'b1;
            grant_id_q  <= pick;
          end
        end
        OWN: begin
          if ((xfer && owner_last) || timeout) begin
            state_q     <= IDLE;
            grant_vld_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            idle_cnt_q  <= '0;
          end else if (owner_valid) begin
            idle_cnt_q <= '0;
          end else if (IDLE_TIMEOUT > 0) begin
            // Only silence counts; a full-FIFO stall keeps valid high and clears the count.
            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
